// File: rtl/fifo_rd_burst_drain_if.sv
// Valid/ready output stream of the FIFO read-side burst drainer.
// The master drives data/valid/last and the slave drives ready.
interface fifo_rd_burst_drain_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_burst_drain.sv
// Read-domain FIFO consumer: fixed-length read bursts into a 3-entry skid buffer feeding a valid/ready stream.
// Optional macro FIFO_RD_STATS_EN adds a saturating 16-bit stream handshake counter (words_read).
module fifo_rd_burst_drain_chk (
    input logic       clk,
    input logic       rst,
    input logic [2:0] occ
);
    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= 3'd3);
endmodule

module fifo_rd_burst_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                   clk_rd,
    input  logic                   rst,
    input  logic                   empty,
    input  logic [DATA_WIDTH-1:0]  data_out,
    output logic                   rd_en,
    fifo_rd_burst_drain_if.master  m_if,
`ifdef FIFO_RD_STATS_EN
    output logic [15:0]            words_read,
`endif
    output logic                   busy
);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_rcnt;
    logic [CNT_W-1:0]      w_rcnt_nxt;
    logic [CNT_W-1:0]      r_ocnt;
    logic [2:0]            r_occ;
    logic [2:0]            w_occ_nxt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_skid [3];
    logic [DATA_WIDTH-1:0] w_skid_nxt [3];
    logic [1:0]            w_tail;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_rd_en;

    assign w_valid = (r_occ != 3'd0);
    assign w_last  = w_valid & (r_ocnt == LAST_IDX);
    assign w_pop   = w_valid & m_if.m_ready;
    // Reserve a skid slot for every read whose data is still on its way.
    assign w_rd_en = (r_state == ST_BURST) & ~empty & ((r_occ + {2'b00, r_inflight}) < 3'd3);

    assign rd_en        = w_rd_en;
    assign m_if.m_data  = r_skid[0];
    assign m_if.m_valid = w_valid;
    assign m_if.m_last  = w_last;
    assign busy         = (r_state != ST_IDLE) | (r_occ != 3'd0) | r_inflight;

    // Next-state and read-counter logic of the burst FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        case (r_state)
            ST_IDLE: begin
                if (!empty) begin
                    w_state_nxt = ST_BURST;
                    w_rcnt_nxt  = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_rd_en && (r_rcnt == LAST_IDX)) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_rd_en) begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_WAIT: begin
                if (w_pop && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Skid buffer update: shift on pop, then write the captured word at the tail.
    always_comb begin
        w_skid_nxt[0] = r_skid[0];
        w_skid_nxt[1] = r_skid[1];
        w_skid_nxt[2] = r_skid[2];
        w_tail        = w_pop ? (r_occ[1:0] - 2'd1) : r_occ[1:0];
        if (w_pop) begin
            w_skid_nxt[0] = r_skid[1];
            w_skid_nxt[1] = r_skid[2];
        end else begin
            w_skid_nxt[0] = r_skid[0];
        end
        if (r_inflight) begin
            case (w_tail)
                2'd0:    w_skid_nxt[0] = data_out;
                2'd1:    w_skid_nxt[1] = data_out;
                2'd2:    w_skid_nxt[2] = data_out;
                default: w_skid_nxt[2] = r_skid[2];
            endcase
        end else begin
            w_skid_nxt[2] = w_skid_nxt[2];
        end
        case ({r_inflight, w_pop})
            2'b10:   w_occ_nxt = r_occ + 3'd1;
            2'b01:   w_occ_nxt = r_occ - 3'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // State, counters and skid storage registers.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rcnt     <= {CNT_W{1'b0}};
            r_ocnt     <= {CNT_W{1'b0}};
            r_occ      <= 3'd0;
            r_inflight <= 1'b0;
            r_skid[0]  <= {DATA_WIDTH{1'b0}};
            r_skid[1]  <= {DATA_WIDTH{1'b0}};
            r_skid[2]  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_occ      <= w_occ_nxt;
            r_inflight <= w_rd_en;
            r_skid[0]  <= w_skid_nxt[0];
            r_skid[1]  <= w_skid_nxt[1];
            r_skid[2]  <= w_skid_nxt[2];
            if (w_pop) begin
                r_ocnt <= (r_ocnt == LAST_IDX) ? {CNT_W{1'b0}} : (r_ocnt + 1'b1);
            end else begin
                r_ocnt <= r_ocnt;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] r_words_read;

    // Saturating count of stream handshakes.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            r_words_read <= 16'h0000;
        end else if (w_pop && (r_words_read != 16'hFFFF)) begin
            r_words_read <= r_words_read + 16'h0001;
        end else begin
            r_words_read <= r_words_read;
        end
    end

    assign words_read = r_words_read;
`endif

    fifo_rd_burst_drain_chk u_chk (
        .clk (clk_rd),
        .rst (rst),
        .occ (r_occ)
    );
endmodule
